note_tracker: RTL and testbench

//   Tracks the notes currently held in the 8-bit note message stream on clk_msg.

---
 rtl/note_tracker.sv | 130 +++++++++++++
 tb/tb_note_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_tracker.sv
// Last-note-priority stack of held notes, driven by an 8-bit note message stream.
// Reports the most recent held note, held count and a sticky overflow flag.
module note_tracker #(
  parameter int NOTE_W = 7,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int MSG_W = NOTE_W + 1
) (
  input  logic              clk_msg,
  input  logic              rst,
  input  logic              en,
  input  logic [MSG_W-1:0]  msg,
  input  logic              hold,
  output logic [NOTE_W-1:0] top_note,
  output logic              top_valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  logic [NOTE_W-1:0] stk_reg  [DEPTH];
  logic [NOTE_W-1:0] stk_next [DEPTH];
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [NOTE_W-1:0] last_note_reg, last_note_next;
  logic              overflow_reg, overflow_next;

  logic              is_on;
  logic [NOTE_W-1:0] id;
  logic [DEPTH-1:0]  match;
  logic              hit;
  logic [CNT_W-1:0]  hit_idx;
  logic              full;
  logic              do_remove, do_append;
  logic [CNT_W-1:0]  rem_idx, app_idx;
  logic [NOTE_W-1:0] new_top, cur_top;

  assign is_on = msg[MSG_W-1];
  assign id    = msg[NOTE_W-1:0];
  assign full  = (count_reg == CNT_W'(DEPTH));

  // Only entries below count take part in the search.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = (CNT_W'(gi) < count_reg) && (stk_reg[gi] == id);
    end
  endgenerate

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = CNT_W'(i);
      end
    end
  end

  // Every update is "remove one entry, compact above it, optionally append id on top".
  always_comb begin
    do_remove     = 1'b0;
    do_append     = 1'b0;
    rem_idx       = '0;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (is_on) begin
      do_append = 1'b1;
      if (hit) begin
        do_remove = 1'b1;
        rem_idx   = hit_idx;
      end else if (full) begin
        do_remove     = 1'b1;
        rem_idx       = '0;
        overflow_next = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end else if (hit) begin
      do_remove  = 1'b1;
      rem_idx    = hit_idx;
      count_next = count_reg - 1'b1;
    end
  end

  assign app_idx = count_next - 1'b1;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [NOTE_W-1:0] shifted;
      if (gi < DEPTH - 1) begin : g_mid
        assign shifted = stk_reg[gi+1];
      end else begin : g_last
        assign shifted = stk_reg[gi];
      end
      assign stk_next[gi] = (do_append && app_idx == CNT_W'(gi)) ? id :
                            (do_remove && CNT_W'(gi) >= rem_idx) ? shifted :
                            stk_reg[gi];
    end
  endgenerate

  always_comb begin
    new_top = '0;
    cur_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) == count_next - 1'b1) new_top = stk_next[i];
      if (CNT_W'(i) == count_reg - 1'b1)  cur_top = stk_reg[i];
    end
    last_note_next = (count_next != '0) ? new_top : last_note_reg;
  end

  always_ff @(posedge clk_msg or posedge rst) begin
    if (rst) begin
      count_reg     <= '0;
      last_note_reg <= '0;
      overflow_reg  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_reg[i] <= '0;
    end else if (en) begin
      count_reg     <= count_next;
      last_note_reg <= last_note_next;
      overflow_reg  <= overflow_next;
      for (int i = 0; i < DEPTH; i++) stk_reg[i] <= stk_next[i];
    end
  end

  assign top_valid = (count_reg != '0);
  assign top_note  = top_valid ? cur_top : (hold ? last_note_reg : '0);
  assign count     = count_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_note_tracker.sv
// Bench for note_tracker: directed scenarios plus a random message stream
// checked against an ordered-list model of the held notes.
module tb_note_tracker;
  localparam int NOTE_W = 7;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int MSG_W  = NOTE_W + 1;

  logic              clk_msg = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [MSG_W-1:0]  msg = '0;
  logic              hold = 1'b0;
  logic [NOTE_W-1:0] top_note;
  logic              top_valid;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: ordered list, oldest first, newest last.
  int q[$];
  int last_m = 0;
  bit ovf_m = 1'b0;

  note_tracker #(.NOTE_W(NOTE_W), .DEPTH(DEPTH)) dut (
    .clk_msg(clk_msg), .rst(rst), .en(en), .msg(msg), .hold(hold),
    .top_note(top_note), .top_valid(top_valid), .count(count), .overflow(overflow)
  );

  always #5 clk_msg = ~clk_msg;

  function automatic int find_idx(int nid);
    for (int i = 0; i < q.size(); i++) if (q[i] == nid) return i;
    return -1;
  endfunction

  function automatic void model_apply(bit on, int nid);
    int p;
    p = find_idx(nid);
    if (on) begin
      if (p >= 0) q.delete(p);
      else if (q.size() == DEPTH) begin
        void'(q.pop_front());
        ovf_m = 1'b1;
      end
      q.push_back(nid);
    end else if (p >= 0) begin
      q.delete(p);
    end
    if (q.size() > 0) last_m = q[$];
  endfunction

  function automatic int exp_top();
    if (q.size() > 0) return q[$];
    return hold ? last_m : 0;
  endfunction

  task automatic send(input bit on, input int nid, input bit e);
    @(negedge clk_msg);
    msg = {on, NOTE_W'(nid)};
    en  = e;
    @(posedge clk_msg);
    #1;
    en = 1'b0;
    if (e) model_apply(on, nid);
    $display("[TB] msg on=%0d id=%0d en=%0d -> count=%0d top=%0d valid=%0d ovf=%0d",
             on, nid, e, count, top_note, top_valid, overflow);
  endtask

  task automatic do_reset();
    @(negedge clk_msg);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    q.delete();
    last_m = 0;
    ovf_m = 1'b0;
  endtask

  task automatic test_reset();
    hold = 1'b1;
    do_reset();
    tests_run++;
    if (top_note !== '0 || top_valid !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: top=%0d valid=%0d count=%0d ovf=%0d, required all 0",
               top_note, top_valid, count, overflow);
    end
    hold = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    send(1, 5, 1);
    send(1, 3, 1);
    tests_run++;
    if (top_note !== 7'd3 || count !== 4'd2 || top_valid !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_on: top=%0d count=%0d valid=%0d ovf=%0d, required 3 2 1 0",
               top_note, count, top_valid, overflow);
    end
    send(0, 3, 1);
    tests_run++;
    if (top_note !== 7'd5 || count !== 4'd1) begin
      tests_failed++;
      $display("FAIL basic_off: top=%0d count=%0d, required 5 1", top_note, count);
    end
    send(0, 5, 1);
    tests_run++;
    if (top_note !== 7'd0 || top_valid !== 1'b0 || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL empty_nohold: top=%0d valid=%0d count=%0d, required 0 0 0",
               top_note, top_valid, count);
    end
    hold = 1'b1;
    #1;
    tests_run++;
    if (top_note !== 7'd5 || top_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_immediate: top=%0d valid=%0d, required 5 0", top_note, top_valid);
    end
    hold = 1'b0;
  endtask

  task automatic test_repress();
    do_reset();
    send(1, 1, 1);
    send(1, 2, 1);
    send(1, 3, 1);
    send(1, 1, 1);
    tests_run++;
    if (count !== 4'd3 || top_note !== 7'd1) begin
      tests_failed++;
      $display("FAIL repress: count=%0d top=%0d, required 3 1", count, top_note);
    end
    send(0, 3, 1);
    tests_run++;
    if (count !== 4'd2 || top_note !== 7'd1) begin
      tests_failed++;
      $display("FAIL repress_off_mid: count=%0d top=%0d, required 2 1", count, top_note);
    end
    send(0, 1, 1);
    tests_run++;
    if (count !== 4'd1 || top_note !== 7'd2) begin
      tests_failed++;
      $display("FAIL repress_order: count=%0d top=%0d, required 1 2", count, top_note);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) send(1, i, 1);
    tests_run++;
    if (count !== 4'd8 || overflow !== 1'b1 || top_note !== 7'd9) begin
      tests_failed++;
      $display("FAIL overflow: count=%0d ovf=%0d top=%0d, required 8 1 9",
               count, overflow, top_note);
    end
    send(0, 1, 1);
    tests_run++;
    if (count !== 4'd8 || top_note !== 7'd9) begin
      tests_failed++;
      $display("FAIL dropped_off: count=%0d top=%0d, required 8 9", count, top_note);
    end
    // Popping from the top exposes the stack order 9..2.
    for (int i = 9; i >= 3; i--) begin
      send(0, i, 1);
      tests_run++;
      if (top_note !== NOTE_W'(i - 1) || count !== CNT_W'(i - 2) || overflow !== 1'b1) begin
        tests_failed++;
        $display("FAIL overflow_order: top=%0d count=%0d ovf=%0d, required %0d %0d 1",
                 top_note, count, overflow, i - 1, i - 2);
      end
    end
  endtask

  task automatic test_enable_async();
    do_reset();
    send(1, 4, 1);
    send(1, 10, 0);
    tests_run++;
    if (count !== 4'd1 || top_note !== 7'd4) begin
      tests_failed++;
      $display("FAIL en_low: count=%0d top=%0d, required 1 4", count, top_note);
    end
    do_reset();
    send(0, 7, 1);
    tests_run++;
    if (count !== 4'd0 || top_valid !== 1'b0 || top_note !== 7'd0) begin
      tests_failed++;
      $display("FAIL stray_off: count=%0d valid=%0d top=%0d, required 0 0 0",
               count, top_valid, top_note);
    end
    for (int i = 1; i <= 9; i++) send(1, i + 20, 1);
    hold = 1'b1;
    @(negedge clk_msg);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (top_note !== '0 || top_valid !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_rst: top=%0d valid=%0d count=%0d ovf=%0d, required all 0",
               top_note, top_valid, count, overflow);
    end
    #1;
    rst = 1'b0;
    hold = 1'b0;
    q.delete();
    last_m = 0;
    ovf_m = 1'b0;
  endtask

  task automatic test_random();
    bit on, e;
    int nid;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      on   = ($urandom_range(0, 99) < 60);
      nid  = $urandom_range(0, 11);
      e    = ($urandom_range(0, 9) != 0);
      hold = 1'($urandom_range(0, 1));
      send(on, nid, e);
      tests_run++;
      if (count !== CNT_W'(q.size()) || top_note !== NOTE_W'(exp_top()) ||
          top_valid !== (q.size() > 0) || overflow !== ovf_m) begin
        tests_failed++;
        $display("FAIL random[%0d]: count=%0d top=%0d valid=%0d ovf=%0d, required %0d %0d %0d %0d",
                 n, count, top_note, top_valid, overflow,
                 q.size(), exp_top(), q.size() > 0, ovf_m);
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repress();
    test_overflow();
    test_enable_async();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
